// File: rtl/wb_issue_scheduler.sv
// Decode-side issue scheduler: a writeback-timing shift table of in-flight
// register writes that resolves wb-port, RAW-on-mult and WAW hazards.
module wb_issue_scheduler #(
  parameter int ALU_WB_LAT = 4,
  parameter int MUL_WB_LAT = 6
) (
  input  logic        clk_i,
  input  logic        rsn_i,
  input  logic        dec_valid_i,
  input  logic [4:0]  dec_rs1_addr_i,
  input  logic        dec_rs1_use_i,
  input  logic [4:0]  dec_rs2_addr_i,
  input  logic        dec_rs2_use_i,
  input  logic [4:0]  dec_rd_addr_i,
  input  logic        dec_wr_en_i,
  input  logic        dec_is_mult_i,
  input  logic        pipe_stall_i,
  output logic        issue_o,
  output logic        stall_core_o,
  output logic        wb_valid_o,
  output logic [4:0]  wb_addr_o,
  output logic [31:0] pending_o
);
  localparam int D = MUL_WB_LAT;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_mult;
  } slot_t;

  slot_t [D-1:0] slot_q, slot_d;
  logic eff_wr, raw, waw, strct, hazard;

  function automatic logic src_hit(input logic [4:0] addr, input logic use_, input logic [4:0] rd);
    return use_ && (addr != 5'd0) && (addr == rd);
  endfunction

  assign eff_wr = dec_wr_en_i & (dec_rd_addr_i != 5'd0);

  // Mult results at slot 0 are on the wb bus and bypassable; ALU results always are.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (slot_q[k].valid) begin
        if (k >= 1 && slot_q[k].is_mult &&
            (src_hit(dec_rs1_addr_i, dec_rs1_use_i, slot_q[k].rd) ||
             src_hit(dec_rs2_addr_i, dec_rs2_use_i, slot_q[k].rd)))
          raw = 1'b1;
        if (eff_wr && slot_q[k].rd == dec_rd_addr_i)
          waw = 1'b1;
      end
    end
  end

  // An entry at ALU_WB_LAT shifts into the ALU target slot on this edge.
  assign strct  = eff_wr & ~dec_is_mult_i & slot_q[ALU_WB_LAT].valid;
  assign hazard = dec_valid_i & (raw | waw | strct);

  assign stall_core_o = rsn_i & (pipe_stall_i | hazard);
  assign issue_o      = rsn_i & dec_valid_i & ~(pipe_stall_i | hazard);

  always_comb begin
    slot_d = {slot_t'('0), slot_q[D-1:1]};
    if (issue_o && eff_wr) begin
      if (dec_is_mult_i)
        slot_d[D-1] = '{valid: 1'b1, rd: dec_rd_addr_i, is_mult: 1'b1};
      else
        slot_d[ALU_WB_LAT-1] = '{valid: 1'b1, rd: dec_rd_addr_i, is_mult: 1'b0};
    end
  end

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i)
      slot_q <= '0;
    else if (!pipe_stall_i)
      slot_q <= slot_d;
  end

  assign wb_valid_o = slot_q[0].valid & ~pipe_stall_i;
  assign wb_addr_o  = wb_valid_o ? slot_q[0].rd : 5'd0;

  always_comb begin
    pending_o = '0;
    for (int k = 0; k < D; k++)
      if (slot_q[k].valid) pending_o[slot_q[k].rd] = 1'b1;
    pending_o[0] = 1'b0;
  end
endmodule

// File: tb/tb_wb_issue_scheduler.sv
// Bench for wb_issue_scheduler: directed scenarios plus random traffic, all
// checked against a list-of-in-flight-writes model with countdowns to wb.
module tb_wb_issue_scheduler;
  localparam int ALU = 4;
  localparam int MUL = 6;

  logic clk = 1'b0;
  logic rsn;
  logic dec_valid_i, dec_rs1_use_i, dec_rs2_use_i, dec_wr_en_i, dec_is_mult_i, pipe_stall_i;
  logic [4:0] dec_rs1_addr_i, dec_rs2_addr_i, dec_rd_addr_i;
  logic issue_o, stall_core_o, wb_valid_o;
  logic [4:0] wb_addr_o;
  logic [31:0] pending_o;

  always #5 clk = ~clk;

  wb_issue_scheduler #(.ALU_WB_LAT(ALU), .MUL_WB_LAT(MUL)) dut (
    .clk_i(clk), .rsn_i(rsn),
    .dec_valid_i(dec_valid_i),
    .dec_rs1_addr_i(dec_rs1_addr_i), .dec_rs1_use_i(dec_rs1_use_i),
    .dec_rs2_addr_i(dec_rs2_addr_i), .dec_rs2_use_i(dec_rs2_use_i),
    .dec_rd_addr_i(dec_rd_addr_i), .dec_wr_en_i(dec_wr_en_i),
    .dec_is_mult_i(dec_is_mult_i), .pipe_stall_i(pipe_stall_i),
    .issue_o(issue_o), .stall_core_o(stall_core_o),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .pending_o(pending_o)
  );

  // In-flight write: cyc = edges remaining until it is the one writing back.
  typedef struct { int rd; int cyc; bit mul; } ent_t;
  ent_t mq[$];

  int n_chk = 0;
  int n_pass = 0;
  logic o_issue, o_stall, o_wbv;
  logic [4:0] o_wba;
  logic [31:0] o_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // One cycle: drive at negedge, check mid-low-phase, advance model at posedge.
  task automatic step(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit we, input bit mul, input bit ps);
    bit eff, raw, waw, st, hz, e_stall, e_issue, e_wbv;
    int e_wba, t;
    logic [31:0] e_pend;
    ent_t nq[$];
    dec_valid_i = v; dec_rs1_addr_i = rs1[4:0]; dec_rs1_use_i = u1;
    dec_rs2_addr_i = rs2[4:0]; dec_rs2_use_i = u2; dec_rd_addr_i = rd[4:0];
    dec_wr_en_i = we; dec_is_mult_i = mul; pipe_stall_i = ps;
    #1;
    eff = we && rd != 0;
    t = mul ? MUL - 1 : ALU - 1;
    raw = 0; waw = 0; st = 0; e_wbv = 0; e_wba = 0; e_pend = '0;
    foreach (mq[i]) begin
      if (mq[i].mul && mq[i].cyc >= 1 &&
          ((u1 && rs1 != 0 && rs1 == mq[i].rd) || (u2 && rs2 != 0 && rs2 == mq[i].rd)))
        raw = 1;
      if (eff && mq[i].rd == rd) waw = 1;
      // the new write would land in wb on the same cycle as this one
      if (eff && mq[i].cyc - 1 == t) st = 1;
      if (mq[i].cyc == 0 && !ps) begin e_wbv = 1; e_wba = mq[i].rd; end
      e_pend[mq[i].rd] = 1'b1;
    end
    hz = v && (raw || waw || st);
    e_stall = ps || hz;
    e_issue = v && !e_stall;
    o_issue = issue_o; o_stall = stall_core_o; o_wbv = wb_valid_o;
    o_wba = wb_addr_o; o_pend = pending_o;
    chk("issue", {31'd0, o_issue}, {31'd0, e_issue});
    chk("stall", {31'd0, o_stall}, {31'd0, e_stall});
    chk("wb_valid", {31'd0, o_wbv}, {31'd0, e_wbv});
    chk("wb_addr", {27'd0, o_wba}, e_wba);
    chk("pending", o_pend, e_pend);
    @(posedge clk);
    if (!ps) begin
      foreach (mq[i]) if (mq[i].cyc > 0) nq.push_back('{mq[i].rd, mq[i].cyc - 1, mq[i].mul});
      if (e_issue && eff) nq.push_back('{rd, t, mul});
      mq = nq;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Async reset with an eager decode and a downstream stall: all outputs must read 0.
  task automatic do_reset();
    rsn = 1'b0;
    dec_valid_i = 1'b1; dec_wr_en_i = 1'b1; dec_rd_addr_i = 5'd5; pipe_stall_i = 1'b1;
    #1;
    chk("rst_issue", {31'd0, issue_o}, 32'd0);
    chk("rst_stall", {31'd0, stall_core_o}, 32'd0);
    chk("rst_wbv", {31'd0, wb_valid_o}, 32'd0);
    chk("rst_wba", {27'd0, wb_addr_o}, 32'd0);
    chk("rst_pend", pending_o, 32'd0);
    mq.delete();
    @(posedge clk);
    @(negedge clk);
    rsn = 1'b1;
    dec_valid_i = 1'b0; pipe_stall_i = 1'b0;
  endtask

  initial begin
    int n, c7, c8, cyc;
    rsn = 1'b1;
    dec_valid_i = 0; dec_rs1_addr_i = 0; dec_rs1_use_i = 0; dec_rs2_addr_i = 0;
    dec_rs2_use_i = 0; dec_rd_addr_i = 0; dec_wr_en_i = 0; dec_is_mult_i = 0; pipe_stall_i = 0;
    @(negedge clk);
    do_reset();
    idle();

    // 1: reset mid-flight with three entries, then ALU latency
    for (int i = 1; i <= 3; i++) step(1, 0, 0, 0, 0, i, 1, 0, 0);
    do_reset();
    idle();
    step(1, 0, 0, 0, 0, 5, 1, 0, 0);
    chk("t1_issue", {31'd0, o_issue}, 32'd1);
    repeat (3) idle();
    idle();
    chk("t1_wbv", {31'd0, o_wbv}, 32'd1);
    chk("t1_wba", {27'd0, o_wba}, 32'd5);
    repeat (4) idle();

    // 2: RAW on a mult result
    step(1, 0, 0, 0, 0, 3, 1, 1, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 3, 1, 0, 0, 10, 1, 0, 0);
      if (o_stall) n++; else break;
    end
    chk("t2_raw_stalls", n, 5);
    chk("t2_issue", {31'd0, o_issue}, 32'd1);
    chk("t2_wbv", {31'd0, o_wbv}, 32'd1);
    chk("t2_wba", {27'd0, o_wba}, 32'd3);
    repeat (8) idle();

    // 3: structural conflict behind a mult
    step(1, 0, 0, 0, 0, 7, 1, 1, 0);
    idle();
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 8, 1, 0, 0);
      if (o_stall) n++; else break;
    end
    chk("t3_struct_stalls", n, 1);
    c7 = -100; c8 = -50;
    for (int i = 0; i < 10; i++) begin
      idle();
      if (o_wbv && o_wba == 5'd7) c7 = i;
      if (o_wbv && o_wba == 5'd8) c8 = i;
    end
    chk("t3_retire_gap", c8 - c7, 1);

    // 4: ALU write/read bypass, pending window, WAW
    step(1, 0, 0, 0, 0, 9, 1, 0, 0);
    step(1, 9, 1, 0, 0, 11, 1, 0, 0);
    chk("t4_nostall", {31'd0, o_stall}, 32'd0);
    n = o_pend[9] ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      idle();
      if (o_pend[9]) n++;
    end
    chk("t4_pend_cycles", n, 4);
    step(1, 0, 0, 0, 0, 9, 1, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 0, 0, 0, 9, 1, 0, 0);
      if (o_stall) n++; else break;
    end
    chk("t4_waw_stalls", n, 4);
    repeat (6) idle();

    // 5: downstream freeze delays a mult by exactly the freeze length
    step(1, 0, 0, 0, 0, 12, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0, 13, 1, 0, 1);
      chk("t5_frz_issue", {31'd0, o_issue}, 32'd0);
      chk("t5_frz_wbv", {31'd0, o_wbv}, 32'd0);
    end
    cyc = -1;
    for (int i = 4; i < 16; i++) begin
      idle();
      if (o_wbv && o_wba == 5'd12 && cyc < 0) cyc = i;
    end
    chk("t5_wb_cycle", cyc, 9);

    // 6: x0 writes and non-writes interleaved with mults
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("t6_x0_stall", {31'd0, o_stall}, 32'd0);
      step(1, 0, 0, 0, 0, 20 + i, 0, 0, 0);
      chk("t6_nowr_stall", {31'd0, o_stall}, 32'd0);
      step(1, 0, 0, 0, 0, 20 + i, 1, 1, 0);
      chk("t6_mul_stall", {31'd0, o_stall}, 32'd0);
      chk("t6_pend0", {31'd0, o_pend[0]}, 32'd0);
    end
    repeat (8) idle();

    // random traffic on a small register set to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 1) == 1,
             $urandom_range(0, 7), $urandom_range(0, 3) != 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_issue_scheduler.md
Name: wb_issue_scheduler

Overview:
- Issue-side scheduler sitting in decode, alongside the bypass controller.
- Tracks every in-flight register write in a writeback-timing shift table. The ALU path is exe→tl→cache→wb. The multiply path is mult1..mult5→wb.
- Sequences issue so that:
  - the single int-register write port is never double-booked;
  - RAW hazards on multiply results that cannot be bypassed stall decode;
  - WAW ordering is preserved.
- Drives the core stall that gates the fetch/decode latches.

Parameters:
- ALU_WB_LAT, 4: edges from issue until an ALU/load result occupies the wb slot.
- MUL_WB_LAT, 6: same, for a multiply. This is also the table depth D. Must be greater than ALU_WB_LAT.

Ports:
- clk_i  in  1  core clock
- rsn_i  in  1  asynchronous active-low reset
- dec_valid_i  in  1  decode holds a valid instruction
- dec_rs1_addr_i  in  5  source A address
- dec_rs1_use_i  in  1  source A is read
- dec_rs2_addr_i  in  5  source B address
- dec_rs2_use_i  in  1  source B is read
- dec_rd_addr_i  in  5  destination address
- dec_wr_en_i  in  1  instruction writes rd
- dec_is_mult_i  in  1  instruction uses the 5-stage multiply path
- pipe_stall_i  in  1  downstream freeze (cache miss); whole pipe holds
- issue_o  out  1  instruction advances into exe this edge
- stall_core_o  out  1  hold fetch/decode latches
- wb_valid_o  out  1  table entry 0 is retiring (writeback) this cycle
- wb_addr_o  out  5  rd of the retiring entry
- pending_o  out  32  bit r set while a write to r is in flight; bit 0 is always 0

Behaviour:
- State: table slot[0..D-1], each holding {valid, rd[4:0], is_mult}. Slot k means "k edges until writeback". No other state.
- Reset (rsn_i low, async): all slots invalid.
  - While reset is asserted or after release: issue_o, stall_core_o, wb_valid_o, wb_addr_o and pending_o are all 0.
  - Reset mid-operation discards all in-flight entries immediately.
- Effective write: dec_wr_en_i=1 and dec_rd_addr_i≠0. Otherwise the instruction inserts nothing and needs no slot.
- Target index: T = MUL_WB_LAT-1 if dec_is_mult_i, else ALU_WB_LAT-1.
- Hazards, evaluated combinationally from the current table plus the decode inputs:
  - RAW: a used source s≠0 matches a valid slot k with is_mult=1 and k≥1. ALU/load entries are always bypassable. A mult at slot 0 is bypassed from wb.
  - WAW: effective write and rd matches any valid slot.
  - Structural: effective write, not mult, and slot[ALU_WB_LAT] is valid. That entry would shift into T, so both would reach wb together. A mult target never conflicts, because slot D does not exist.
- hazard = dec_valid_i & (RAW | WAW | structural).
- stall_core_o = pipe_stall_i | hazard.
- issue_o = dec_valid_i & ~stall_core_o.
- Edge update when pipe_stall_i=0:
  - slot[k] ← slot[k+1] for k < D-1; slot[D-1] ← invalid;
  - then, if issue_o and effective write, slot[T] ← {1, rd, is_mult}.
  - Slot 0 is dropped (retired).
- Edge update when pipe_stall_i=1: table holds completely; nothing is inserted or retired.
- wb_valid_o = slot[0].valid & ~pipe_stall_i.
- wb_addr_o = slot[0].rd when wb_valid_o=1, else 0.
- pending_o[r] = OR over valid slots with rd=r. This is one-hot per slot, because WAW guarantees at most one entry per rd.
- Latency: an ALU instruction issued at edge t has wb_valid_o high in the cycle after edge t+ALU_WB_LAT-1, i.e. 4 cycles after issue at the defaults. A mult shows it 6 cycles after issue.
- Simultaneous retire and issue to the same rd: WAW is evaluated on the pre-edge table, so the new instruction stalls one cycle. This is accepted.
- x0 never sets pending, never causes RAW, and never reserves a slot.
- At most one insert per edge. No overflow is possible.

Test Plan:
1. Reset asserted mid-flight with 3 valid entries, then released:
   - all outputs read 0;
   - an ALU issue to x5 then shows wb_valid_o=1 with wb_addr_o=5 exactly 4 cycles later.
2. Mult to x3, then an ALU op reading x3 on the next cycle:
   - stall_core_o=1 for 5 cycles, while the x3 entry is at slot ≥1;
   - the consumer issues in the cycle wb_valid_o=1 with wb_addr_o=3.
3. Mult to x7 issued, ALU to x8 presented 2 cycles later:
   - the mult sits at slot 4, so a structural stall of 1 cycle occurs;
   - x7 and x8 retire on consecutive cycles and never coincide.
4. Back-to-back ALU ops writing x9 then reading x9:
   - no stall;
   - pending_o[9]=1 for 4 cycles;
   - two ALU writes to x9 in a row: the second stalls until x9 retires (WAW).
5. pipe_stall_i held high for 3 cycles with a mult in flight:
   - table frozen; wb_valid_o=0; issue_o=0;
   - the mult's writeback is delayed by exactly 3 cycles.
6. Writes to x0, or dec_wr_en_i=0, interleaved with mults:
   - pending_o[0]=0 throughout;
   - no slot is reserved and no stall results.
